// File: rtl/wb_ram_bist_master.sv
// rtl/wb_ram_bist_master.sv - Wishbone classic initiator running a four-pass RAM write/readback self-test
//
// Window: WORDS 32-bit words starting at BASE_ADDR. Pattern P(i) = seed ^ (i * 32'h0101_0101).
// Passes: write P, read/check P, write ~P, read/check ~P. Stops at the first mismatch or ack timeout.
//
// Ports:
//   wb_clk_i, wb_rst_ni         clock, synchronous active-low reset
//   start_i, seed_i             start pulse (honoured in IDLE/DONE), pattern seed latched at start
//   busy_o, done_o              test running / test finished (held until the next start)
//   fail_o, timeout_o           failure flag, failure caused by missing ack
//   fail_addr_o, fail_data_o    byte address and read data of the first failing access
//   wbm_*                       Wishbone classic master port

module wb_ram_bist_master #(
  parameter logic [31:0] BASE_ADDR = 32'h30c0_0000,
  parameter int          WORDS     = 64,
  parameter int          TIMEOUT   = 15
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_ni,
  input  logic        start_i,
  input  logic [31:0] seed_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        fail_o,
  output logic        timeout_o,
  output logic [31:0] fail_addr_o,
  output logic [31:0] fail_data_o,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic        wbm_we_o,
  output logic [3:0]  wbm_sel_o,
  output logic [31:0] wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  input  logic [31:0] wbm_dat_i,
  input  logic        wbm_ack_i
);

  localparam logic [15:0] LAST_IDX    = 16'(WORDS - 1);
  localparam logic [7:0]  TIMEOUT_CNT = 8'(TIMEOUT);
  localparam logic [31:0] STEP        = 32'h0101_0101;

  typedef enum logic [1:0] {IDLE, REQ, GAP, DONE} state_t;

  state_t      state_q, state_d;
  logic [31:0] seed_q;
  logic [31:0] mul_q;        // running i * STEP, avoids a multiplier
  logic [15:0] idx_q;
  logic [1:0]  pass_q;       // bit 0: read pass, bit 1: inverted pattern
  logic [7:0]  wait_q;
  logic        fail_q, timeout_q;
  logic [31:0] fail_addr_q, fail_data_q;

  logic        is_read, last_access, mismatch, timed_out;
  logic [31:0] cur_addr, expected;

  assign is_read     = pass_q[0];
  assign cur_addr    = BASE_ADDR + {14'd0, idx_q, 2'b00};
  assign expected    = pass_q[1] ? ~(seed_q ^ mul_q) : (seed_q ^ mul_q);
  assign last_access = (pass_q == 2'd3) && (idx_q == LAST_IDX);
  assign mismatch    = is_read && (wbm_dat_i != expected);
  assign timed_out   = (wait_q == TIMEOUT_CNT);

  // State register
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_ni) state_q <= IDLE;
    else            state_q <= state_d;
  end

  // Next-state logic; an ack in the cycle the wait counter hits TIMEOUT still counts
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE: if (start_i) state_d = REQ;
      REQ: begin
        if (wbm_ack_i) begin
          if (mismatch || last_access) state_d = DONE;
          else                         state_d = GAP;
        end else if (timed_out) begin
          state_d = DONE;
        end
      end
      GAP:     state_d = REQ;
      default: state_d = IDLE;
    endcase
  end

  // Walk position, wait counter and failure record
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_ni) begin
      seed_q      <= '0;
      mul_q       <= '0;
      idx_q       <= '0;
      pass_q      <= '0;
      wait_q      <= '0;
      fail_q      <= 1'b0;
      timeout_q   <= 1'b0;
      fail_addr_q <= '0;
      fail_data_q <= '0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (start_i) begin
            seed_q      <= seed_i;
            mul_q       <= '0;
            idx_q       <= '0;
            pass_q      <= '0;
            wait_q      <= '0;
            fail_q      <= 1'b0;
            timeout_q   <= 1'b0;
            fail_addr_q <= '0;
            fail_data_q <= '0;
          end
        end
        REQ: begin
          if (wbm_ack_i) begin
            wait_q <= '0;
            if (mismatch) begin
              fail_q      <= 1'b1;
              fail_addr_q <= cur_addr;
              fail_data_q <= wbm_dat_i;
            end else if (!last_access) begin
              if (idx_q == LAST_IDX) begin
                idx_q  <= '0;
                mul_q  <= '0;
                pass_q <= pass_q + 2'd1;
              end else begin
                idx_q <= idx_q + 16'd1;
                mul_q <= mul_q + STEP;
              end
            end
          end else if (timed_out) begin
            fail_q      <= 1'b1;
            timeout_q   <= 1'b1;
            fail_addr_q <= cur_addr;
            fail_data_q <= '0;
          end else begin
            wait_q <= wait_q + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // Outputs decode flops only, so they change just after clock edges
  always_comb begin
    busy_o    = (state_q == REQ) || (state_q == GAP);
    done_o    = (state_q == DONE);
    wbm_cyc_o = 1'b0;
    wbm_stb_o = 1'b0;
    wbm_we_o  = 1'b0;
    wbm_sel_o = 4'h0;
    wbm_adr_o = '0;
    wbm_dat_o = '0;
    if (state_q == REQ) begin
      wbm_cyc_o = 1'b1;
      wbm_stb_o = 1'b1;
      wbm_sel_o = 4'hF;
      wbm_adr_o = cur_addr;
      wbm_we_o  = !is_read;
      wbm_dat_o = is_read ? 32'h0 : expected;
    end
  end

  assign fail_o      = fail_q;
  assign timeout_o   = timeout_q;
  assign fail_addr_o = fail_addr_q;
  assign fail_data_o = fail_data_q;

endmodule

// File: tb/tb_wb_ram_bist_master.sv
// tb/tb_wb_ram_bist_master.sv - self-checking bench for wb_ram_bist_master

module tb_wb_ram_bist_master;

  localparam logic [31:0] BASE = 32'h30c0_0000;
  localparam int W   = 4;
  localparam int TMO = 15;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] seed = 32'h0;
  logic        busy_o, done_o, fail_o, timeout_o;
  logic [31:0] fail_addr_o, fail_data_o;
  logic        cyc_o, stb_o, we_o;
  logic [3:0]  sel_o;
  logic [31:0] adr_o, dat_o;
  logic [31:0] dat_i = 32'h0;
  logic        ack = 1'b0;

  always #5 clk = ~clk;

  wb_ram_bist_master #(.BASE_ADDR(BASE), .WORDS(W), .TIMEOUT(TMO)) dut (
    .wb_clk_i(clk), .wb_rst_ni(rst_n), .start_i(start), .seed_i(seed),
    .busy_o(busy_o), .done_o(done_o), .fail_o(fail_o), .timeout_o(timeout_o),
    .fail_addr_o(fail_addr_o), .fail_data_o(fail_data_o),
    .wbm_cyc_o(cyc_o), .wbm_stb_o(stb_o), .wbm_we_o(we_o), .wbm_sel_o(sel_o),
    .wbm_adr_o(adr_o), .wbm_dat_o(dat_o), .wbm_dat_i(dat_i), .wbm_ack_i(ack)
  );

  int vectors = 0;
  int errors  = 0;

  typedef struct {
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat;
  } acc_t;

  acc_t        exp_q[$];
  logic [31:0] w_adr[$];
  logic [31:0] w_dat[$];
  logic [31:0] mem[W];

  int       r_cycles, r_seq_errs, r_stable_errs, r_gap_errs, r_busy_errs;
  int       r_stb_cycles, r_acc, r_post_cyc;
  logic [2:0] r_start_flags;

  function automatic logic [31:0] pat(input logic [31:0] s, input int i);
    logic [31:0] ii;
    ii = i;
    return s ^ (ii * 32'h0101_0101);
  endfunction

  // Reference: the full ordered list of accesses a correct test performs
  task automatic build_ref(input logic [31:0] s);
    acc_t a;
    exp_q.delete();
    for (int p = 0; p < 4; p++)
      for (int i = 0; i < W; i++) begin
        a.we  = (p % 2 == 0);
        a.adr = BASE + 32'(4 * i);
        a.dat = (p < 2) ? pat(s, i) : ~pat(s, i);
        exp_q.push_back(a);
      end
  endtask

  // Starts a test and plays a memory slave acking `lat` cycles after stb rises.
  // flip_acc: access number whose read data gets bit 0 flipped; noack_acc: access never acked;
  // abort_acc: return as soon as that access starts. -1 disables each.
  task automatic run_bist(input logic [31:0] s, input int lat, input int flip_acc,
                          input int noack_acc, input int abort_acc);
    acc_t        a;
    logic [31:0] hold_adr, hold_dat, off;
    logic        hold_we;
    int          hi, lo, accn, word;
    logic        aborted;
    hi = 0; lo = 0; accn = 0; word = 0; aborted = 1'b0;
    hold_adr = '0; hold_dat = '0; hold_we = 1'b0;
    build_ref(s);
    w_adr.delete(); w_dat.delete();
    for (int i = 0; i < W; i++) mem[i] = $urandom;
    r_seq_errs = 0; r_stable_errs = 0; r_gap_errs = 0; r_busy_errs = 0;
    r_stb_cycles = 0; r_post_cyc = 0;
    @(negedge clk);
    start = 1'b1; seed = s;
    @(posedge clk); #1;
    start = 1'b0; seed = $urandom;
    r_cycles = 1;
    r_start_flags = {done_o, fail_o, timeout_o};
    while (!done_o && r_cycles < 3000) begin
      if (busy_o !== 1'b1) r_busy_errs++;
      if (cyc_o && stb_o) begin
        r_stb_cycles++;
        if (hi == 0) begin
          if (abort_acc == accn) begin
            aborted = 1'b1;
            break;
          end
          if (accn > 0 && lo != 1) r_gap_errs++;
          lo = 0;
          if (exp_q.size() == 0) r_seq_errs++;
          else begin
            a = exp_q.pop_front();
            if (we_o !== a.we || adr_o !== a.adr || sel_o !== 4'hF ||
                dat_o !== (a.we ? a.dat : 32'h0)) r_seq_errs++;
          end
          hold_adr = adr_o; hold_dat = dat_o; hold_we = we_o;
          off = adr_o - BASE;
          if (off[1:0] != 2'b00 || off[31:2] >= 30'(W)) begin
            r_seq_errs++;
            word = 0;
          end else word = int'(off[31:2]);
          if (we_o) begin
            mem[word] = dat_o;
            w_adr.push_back(adr_o);
            w_dat.push_back(dat_o);
          end
          accn++;
        end else if (adr_o !== hold_adr || we_o !== hold_we || dat_o !== hold_dat || sel_o !== 4'hF)
          r_stable_errs++;
        hi++;
        ack   = (hi == lat) && (accn - 1 != noack_acc);
        dat_i = $urandom;
        if (ack && !we_o) dat_i = mem[word] ^ {31'b0, (accn - 1 == flip_acc)};
      end else begin
        if (sel_o !== 4'h0) r_seq_errs++;
        hi = 0;
        lo++;
        ack = 1'b0;
        dat_i = $urandom;
      end
      start = ($urandom_range(0, 3) == 0);  // must be ignored while busy
      seed  = $urandom;
      @(posedge clk); #1;
      r_cycles++;
    end
    start = 1'b0;
    ack   = 1'b0;
    r_acc = accn;
    if (!aborted)
      repeat (4) begin
        if (cyc_o || stb_o) r_post_cyc++;
        @(posedge clk); #1;
      end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b1;
    seed  = $urandom;
    repeat (3) begin
      @(posedge clk); #1;
      vectors++;
      if ({busy_o, done_o, fail_o, timeout_o, fail_addr_o, fail_data_o, cyc_o, stb_o, we_o, sel_o, adr_o, dat_o} !== '0) begin
        errors++;
        $display("FAIL reset_outputs busy=%b done=%b fail=%b cyc=%b adr=%h want all zero", busy_o, done_o, fail_o, cyc_o, adr_o);
      end
    end
    start = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    vectors++;
    if ({busy_o, cyc_o, done_o} !== 3'b000) begin
      errors++;
      $display("FAIL reset_release_idle busy=%b cyc=%b done=%b want 000", busy_o, cyc_o, done_o);
    end
  endtask

  task automatic test_pass();
    logic [31:0] want_dat[4];
    want_dat[0] = 32'hA5A5_0000; want_dat[1] = 32'hA4A4_0101;
    want_dat[2] = 32'hA7A7_0202; want_dat[3] = 32'hA6A6_0303;
    run_bist(32'hA5A5_0000, 1, -1, -1, -1);
    vectors++;
    if (r_cycles !== 32) begin errors++; $display("FAIL pass_cycles got %0d want 32", r_cycles); end
    vectors++;
    if ({done_o, fail_o, timeout_o, busy_o} !== 4'b1000) begin
      errors++; $display("FAIL pass_flags done/fail/tmo/busy got %b want 1000", {done_o, fail_o, timeout_o, busy_o});
    end
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (w_adr[i] !== BASE + 32'(4 * i) || w_dat[i] !== want_dat[i]) begin
        errors++; $display("FAIL pass_write%0d got %h/%h want %h/%h", i, w_adr[i], w_dat[i], BASE + 32'(4 * i), want_dat[i]);
      end
    end
    vectors++;
    if (r_seq_errs + exp_q.size() + r_gap_errs + r_busy_errs + r_post_cyc != 0) begin
      errors++; $display("FAIL pass_sequence seq=%0d left=%0d gap=%0d busy=%0d post=%0d want 0", r_seq_errs, exp_q.size(), r_gap_errs, r_busy_errs, r_post_cyc);
    end
  endtask

  task automatic test_random_pass();
    logic [31:0] s;
    int lat;
    repeat (4) begin
      s = $urandom;
      lat = $urandom_range(1, 4);
      run_bist(s, lat, -1, -1, -1);
      vectors++;
      if (r_cycles !== 4 * W * (lat + 1)) begin
        errors++; $display("FAIL rand_cycles seed=%h lat=%0d got %0d want %0d", s, lat, r_cycles, 4 * W * (lat + 1));
      end
      vectors++;
      if ({done_o, fail_o, timeout_o} !== 3'b100 || r_seq_errs + exp_q.size() + r_gap_errs + r_stable_errs + r_busy_errs != 0) begin
        errors++; $display("FAIL rand_pass seed=%h flags=%b seq=%0d left=%0d gap=%0d stable=%0d want 100/0", s, {done_o, fail_o, timeout_o}, r_seq_errs, exp_q.size(), r_gap_errs, r_stable_errs);
      end
    end
  endtask

  task automatic test_mismatch();
    logic [31:0] s, want_data;
    int lat, k, fa;
    run_bist(32'hA5A5_0000, 1, W + 2, -1, -1);
    vectors++;
    if ({done_o, fail_o, timeout_o} !== 3'b110 || fail_addr_o !== 32'h30c0_0008 || fail_data_o !== 32'hA7A7_0203) begin
      errors++; $display("FAIL mismatch_record flags=%b addr=%h data=%h want 110/30c00008/a7a70203", {done_o, fail_o, timeout_o}, fail_addr_o, fail_data_o);
    end
    vectors++;
    if (r_cycles !== 14 || r_acc !== W + 3 || r_post_cyc !== 0) begin
      errors++; $display("FAIL mismatch_stop cycles=%0d acc=%0d post=%0d want 14/%0d/0", r_cycles, r_acc, r_post_cyc, W + 3);
    end
    repeat (3) begin
      s   = $urandom;
      lat = $urandom_range(1, 3);
      k   = $urandom_range(0, 2 * W - 1);
      fa  = (k < W) ? W + k : 3 * W + (k - W);
      want_data = ((k < W) ? pat(s, k % W) : ~pat(s, k % W)) ^ 32'h1;
      run_bist(s, lat, fa, -1, -1);
      vectors++;
      if ({done_o, fail_o, timeout_o} !== 3'b110 || fail_addr_o !== BASE + 32'(4 * (k % W)) ||
          fail_data_o !== want_data || r_cycles !== (fa + 1) * (lat + 1)) begin
        errors++; $display("FAIL mismatch_rand acc=%0d flags=%b addr=%h data=%h cyc=%0d want 110/%h/%h/%0d", fa, {done_o, fail_o, timeout_o}, fail_addr_o, fail_data_o, r_cycles, BASE + 32'(4 * (k % W)), want_data, (fa + 1) * (lat + 1));
      end
    end
  endtask

  task automatic test_timeout();
    int n, lat;
    run_bist($urandom, 1, -1, 0, -1);
    vectors++;
    if ({done_o, fail_o, timeout_o} !== 3'b111 || fail_addr_o !== BASE || fail_data_o !== 32'h0) begin
      errors++; $display("FAIL timeout_record flags=%b addr=%h data=%h want 111/%h/0", {done_o, fail_o, timeout_o}, fail_addr_o, fail_data_o, BASE);
    end
    vectors++;
    if (r_stb_cycles !== 16 || r_cycles !== 17 || r_post_cyc !== 0) begin
      errors++; $display("FAIL timeout_length stb=%0d cycles=%0d post=%0d want 16/17/0", r_stb_cycles, r_cycles, r_post_cyc);
    end
    n   = $urandom_range(1, 4 * W - 1);
    lat = $urandom_range(1, 3);
    run_bist($urandom, lat, -1, n, -1);
    vectors++;
    if ({done_o, fail_o, timeout_o} !== 3'b111 || fail_addr_o !== BASE + 32'(4 * (n % W)) || r_cycles !== n * (lat + 1) + 17) begin
      errors++; $display("FAIL timeout_rand acc=%0d flags=%b addr=%h cycles=%0d want 111/%h/%0d", n, {done_o, fail_o, timeout_o}, fail_addr_o, r_cycles, BASE + 32'(4 * (n % W)), n * (lat + 1) + 17);
    end
  endtask

  task automatic test_ack_at_timeout();
    run_bist($urandom, TMO + 1, -1, -1, -1);
    vectors++;
    if ({done_o, fail_o, timeout_o} !== 3'b100 || r_cycles !== 4 * W * (TMO + 2)) begin
      errors++; $display("FAIL ack_wins flags=%b cycles=%0d want 100/%0d", {done_o, fail_o, timeout_o}, r_cycles, 4 * W * (TMO + 2));
    end
    run_bist($urandom, TMO + 2, -1, -1, -1);
    vectors++;
    if ({done_o, fail_o, timeout_o} !== 3'b111 || r_cycles !== TMO + 2) begin
      errors++; $display("FAIL ack_too_late flags=%b cycles=%0d want 111/%0d", {done_o, fail_o, timeout_o}, r_cycles, TMO + 2);
    end
  endtask

  task automatic test_wait_states();
    run_bist($urandom, 3, -1, -1, -1);
    vectors++;
    if (r_cycles !== 64 || {done_o, fail_o} !== 2'b10) begin
      errors++; $display("FAIL wait_total cycles=%0d flags=%b want 64/10", r_cycles, {done_o, fail_o});
    end
    vectors++;
    if (r_stable_errs + r_seq_errs + exp_q.size() + r_gap_errs != 0) begin
      errors++; $display("FAIL wait_stable stable=%0d seq=%0d left=%0d gap=%0d want 0", r_stable_errs, r_seq_errs, exp_q.size(), r_gap_errs);
    end
  endtask

  task automatic test_reset_mid();
    run_bist($urandom, 1, W, -1, -1);  // leaves a failure record behind
    run_bist($urandom, 2, -1, -1, W + 1);
    vectors++;
    if (r_start_flags !== 3'b000 || cyc_o !== 1'b1) begin
      errors++; $display("FAIL restart_clears flags=%b cyc=%b want 000/1", r_start_flags, cyc_o);
    end
    rst_n = 1'b0;
    @(posedge clk); #1;
    vectors++;
    if ({cyc_o, stb_o, busy_o, done_o, fail_o} !== 5'b0) begin
      errors++; $display("FAIL reset_mid cyc=%b stb=%b busy=%b done=%b fail=%b want 0", cyc_o, stb_o, busy_o, done_o, fail_o);
    end
    rst_n = 1'b1;
    run_bist($urandom, 1, -1, -1, -1);
    vectors++;
    if ({done_o, fail_o, timeout_o} !== 3'b100 || r_cycles !== 32 || r_seq_errs + exp_q.size() != 0) begin
      errors++; $display("FAIL after_reset_pass flags=%b cycles=%0d seq=%0d want 100/32/0", {done_o, fail_o, timeout_o}, r_cycles, r_seq_errs);
    end
  endtask

  initial begin
    test_reset();
    test_pass();
    test_random_pass();
    test_mismatch();
    test_timeout();
    test_ack_at_timeout();
    test_wait_states();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
